// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared constants and write-FSM encoding for the FIFO controller.
//   DEPTH : default number of FIFO entries (power of two)
//   PTR_W : pointer width, log2(DEPTH)
//   CNT_W : occupancy counter width, holds 0..DEPTH
//   wr_state_e : write-strobe FSM states
package fifo_pkg;

   parameter int unsigned DEPTH = 4;
   parameter int unsigned PTR_W = 2;
   parameter int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [0:0] {
      WR_IDLE   = 1'b0,
      WR_STROBE = 1'b1
   } wr_state_e;

endpackage

// File: rtl/fifo_wr_strobe.sv
// fifo_wr_strobe -- two-state write handshake FSM.
// An accepted write spends exactly one cycle in WR_STROBE, during which the
// registered data_ready strobe is high; the entry is committed on the edge that
// leaves WR_STROBE.
// Ports:
//   clk         : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   wr_en       : upstream write request
//   space_avail : committed occupancy below DEPTH
//   wr_ready    : write accepted this cycle if wr_en is high
//   data_ready  : registered write strobe to the datapath
//   commit      : the current edge commits the strobed entry
module fifo_wr_strobe
   import fifo_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic wr_en,
   input  logic space_avail,
   output logic wr_ready,
   output logic data_ready,
   output logic commit
);

   wr_state_e state_q, state_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= WR_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ready = 1'b0;
      unique case (state_q)
         WR_IDLE: begin
            wr_ready = space_avail;
            if (wr_en && space_avail) begin
               state_d = WR_STROBE;
            end
         end
         // wr_en here is ignored: at most one write per two clocks.
         WR_STROBE: state_d = WR_IDLE;
      endcase
   end

   // Straight decode of the state register, so the strobe is glitch-free and
   // drops as soon as reset is asserted.
   assign data_ready = (state_q == WR_STROBE);
   assign commit     = (state_q == WR_STROBE);

endmodule

// File: rtl/fifo_controller.sv
// fifo_controller -- control path of a single-clock FIFO with an external
// datapath (memory addressed by write_pointer/read_pointer).
// Optional feature: define FIFO_CTRL_LEVEL_EN to drive level/almost_full from
// the occupancy counter; otherwise both are tied low.
// Ports:
//   clk, reset_n   : clock (rising edge), asynchronous active-low reset
//   wr_en/wr_ready : upstream write request / accept
//   rd_en          : downstream read request (zero latency)
//   data_valid     : FIFO holds at least one committed entry
//   data_ready     : registered datapath write strobe
//   write_pointer  : datapath write address
//   read_pointer   : datapath read address
//   full           : committed count == DEPTH
//   overflow       : sticky, write attempted while full
//   underflow      : sticky, read attempted while empty
//   err_clr        : synchronous clear of the sticky flags (set wins)
//   level          : committed occupancy
//   almost_full    : level >= DEPTH-1
module fifo_controller
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH = fifo_pkg::DEPTH,
   parameter int unsigned PTR_W = fifo_pkg::PTR_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   output logic             wr_ready,
   input  logic             rd_en,
   output logic             data_valid,
   output logic             data_ready,
   output logic [PTR_W-1:0] write_pointer,
   output logic [PTR_W-1:0] read_pointer,
   output logic             full,
   output logic             overflow,
   output logic             underflow,
   input  logic             err_clr,
   output logic [PTR_W:0]   level,
   output logic             almost_full
);

   localparam int unsigned CntW = PTR_W + 1;

   logic [CntW-1:0]  count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             space_avail;
   logic             commit;
   logic             rd_fire;

   fifo_wr_strobe u_wr_strobe (
      .clk         (clk),
      .reset_n     (reset_n),
      .wr_en       (wr_en),
      .space_avail (space_avail),
      .wr_ready    (wr_ready),
      .data_ready  (data_ready),
      .commit      (commit)
   );

   assign space_avail = (count_q < CntW'(DEPTH));
   assign data_valid  = (count_q != '0);
   assign full        = (count_q == CntW'(DEPTH));
   assign rd_fire     = rd_en & data_valid;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
      if (commit) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({commit, rd_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // Sticky error flags: a new event in the clearing cycle wins.
      overflow_d  = (overflow_q & ~err_clr) | (wr_en & full);
      underflow_d = (underflow_q & ~err_clr) | (rd_en & ~data_valid);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign write_pointer = wr_ptr_q;
   assign read_pointer  = rd_ptr_q;
   assign overflow      = overflow_q;
   assign underflow     = underflow_q;

`ifdef FIFO_CTRL_LEVEL_EN
   assign level       = count_q;
   assign almost_full = (count_q >= CntW'(DEPTH - 1));
`else
   assign level       = '0;
   assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_controller.sv
// tb_fifo_controller -- directed self-checking bench for fifo_controller
// (DEPTH=4). A small memory stands in for the datapath and is written on each
// clock edge where data_ready is high.
module tb_fifo_controller;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;
`ifdef FIFO_CTRL_LEVEL_EN
   localparam bit LevelEn = 1'b1;
`else
   localparam bit LevelEn = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n;
   logic             wr_en;
   logic             wr_ready;
   logic             rd_en;
   logic             data_valid;
   logic             data_ready;
   logic [PTR_W-1:0] write_pointer;
   logic [PTR_W-1:0] read_pointer;
   logic             full;
   logic             overflow;
   logic             underflow;
   logic             err_clr;
   logic [PTR_W:0]   level;
   logic             almost_full;

   logic [7:0] data_in;
   logic [7:0] mem [DEPTH];
   int         n_commit = 0;
   int         tests    = 0;
   int         failed   = 0;
   int         saved_commit;

   fifo_controller #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .wr_en         (wr_en),
      .wr_ready      (wr_ready),
      .rd_en         (rd_en),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .write_pointer (write_pointer),
      .read_pointer  (read_pointer),
      .full          (full),
      .overflow      (overflow),
      .underflow     (underflow),
      .err_clr       (err_clr),
      .level         (level),
      .almost_full   (almost_full)
   );

   always #5 clk = ~clk;

   // Datapath model: written at the edge that ends the strobe cycle.
   always @(posedge clk) begin
      if (reset_n && data_ready) begin
         mem[write_pointer] <= data_in;
         n_commit           <= n_commit + 1;
      end
   end

   function automatic logic [31:0] exp_level(input int unsigned c);
      return LevelEn ? c : 0;
   endfunction

   function automatic logic [31:0] exp_af(input int unsigned c);
      return (LevelEn && c >= DEPTH - 1) ? 1 : 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      err_clr = 1'b0;
      data_in = 8'h00;
      #12;
      check("rst_wr_ready", wr_ready, 1);
      check("rst_data_valid", data_valid, 0);
      check("rst_data_ready", data_ready, 0);
      check("rst_full", full, 0);
      check("rst_level", level, 0);
      check("rst_almost_full", almost_full, 0);
      check("rst_wptr", write_pointer, 0);
      check("rst_rptr", read_pointer, 0);
      check("rst_overflow", overflow, 0);
      check("rst_underflow", underflow, 0);
      reset_n = 1'b1;

      // Single write of 0xA1, then read it back.
      data_in = 8'hA1;
      wr_en   = 1'b1;
      check("w1_wr_ready", wr_ready, 1);
      step();
      wr_en = 1'b0;
      check("w1_strobe", data_ready, 1);
      check("w1_strobe_wptr", write_pointer, 0);
      check("w1_not_yet_valid", data_valid, 0);
      check("w1_busy", wr_ready, 0);
      step();
      check("w1_strobe_end", data_ready, 0);
      check("w1_wptr", write_pointer, 1);
      check("w1_valid", data_valid, 1);
      check("w1_level", level, exp_level(1));
      check("w1_mem", mem[read_pointer], 8'hA1);
      check("w1_commits", n_commit, 1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("r1_rptr", read_pointer, 1);
      check("r1_empty", data_valid, 0);

      // wr_en held high: one accept every other cycle until full.
      wr_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data_in = 8'h10 + 8'(i);
         check("burst_ready", wr_ready, 1);
         step();
         check("burst_strobe_busy", wr_ready, 0);
         check("burst_strobe", data_ready, 1);
         step();
         check("burst_strobe_end", data_ready, 0);
      end
      check("burst_full", full, 1);
      check("burst_wr_ready", wr_ready, 0);
      check("burst_level", level, exp_level(4));
      check("burst_almost_full", almost_full, exp_af(4));
      check("burst_wptr_wrap", write_pointer, 1);
      check("burst_no_ovf_yet", overflow, 0);
      step();
      check("ovf_set", overflow, 1);
      check("ovf_wptr", write_pointer, 1);
      check("ovf_no_strobe", data_ready, 0);
      wr_en = 1'b0;
      rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_data", mem[read_pointer], 8'h10 + 8'(i));
         step();
      end
      rd_en = 1'b0;
      check("drain_empty", data_valid, 0);
      check("drain_rptr", read_pointer, 1);
      check("ovf_sticky", overflow, 1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("ovf_clr", overflow, 0);

      // Underflow from reset state; set wins over a simultaneous clear.
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      check("rst2_rptr", read_pointer, 0);
      rd_en   = 1'b1;
      err_clr = 1'b1;
      step();
      check("udf_set_wins", underflow, 1);
      err_clr = 1'b0;
      step();
      rd_en = 1'b0;
      check("udf_rptr", read_pointer, 0);
      check("udf_count", data_valid, 0);
      check("udf_sticky", underflow, 1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("udf_clr", underflow, 0);

      // Three entries, then a commit and a read on the same edge.
      wr_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         data_in = 8'h30 + 8'(i / 2);
         step();
      end
      check("three_wptr", write_pointer, 3);
      check("three_level", level, exp_level(3));
      check("three_almost_full", almost_full, exp_af(3));
      check("three_full", full, 0);
      check("three_ready", wr_ready, 1);
      data_in = 8'h33;
      step();
      wr_en = 1'b0;
      rd_en = 1'b1;
      check("both_strobe", data_ready, 1);
      check("both_mem0", mem[read_pointer], 8'h30);
      step();
      rd_en = 1'b0;
      check("both_rptr", read_pointer, 1);
      check("both_wptr_wrap", write_pointer, 0);
      check("both_level", level, exp_level(3));
      check("both_mem3", mem[3], 8'h33);
      check("both_full", full, 0);
      check("both_ready", wr_ready, 1);

      // Reset in the middle of a strobe discards the entry.
      wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      check("abort_strobe", data_ready, 1);
      saved_commit = n_commit;
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_strobe_drop", data_ready, 0);
      check("abort_wptr", write_pointer, 0);
      check("abort_rptr", read_pointer, 0);
      check("abort_valid", data_valid, 0);
      check("abort_level", level, 0);
      reset_n = 1'b1;
      step();
      step();
      check("abort_no_write", n_commit, saved_commit);
      check("abort_still_empty", data_valid, 0);
      check("abort_ready", wr_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
